// File: rtl/elastic_memory_responder_pkg.sv
// Shared parameters and state encoding for the elastic memory responder.
// Sized for one PE-local data memory bank.
package elastic_memory_responder_pkg;

   localparam int DATA_WIDTH    = 32;
   localparam int ADDRESS_WIDTH = 10;
   localparam int LOAD_CYCLE    = 2;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } resp_state_t;

endpackage

// File: rtl/elastic_memory_responder_fifo.sv
// Small in-order response buffer with valid/count/head outputs.
// Entries are cleared by reset so the head reads 0 when empty after reset.
module elastic_response_fifo
   import elastic_memory_responder_pkg::*;
#(
   parameter int DATA_WIDTH = elastic_memory_responder_pkg::DATA_WIDTH,
   parameter int DEPTH      = 2,
   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic                  o_valid,
   output logic [CNT_W-1:0]      o_count,
   output logic [DATA_WIDTH-1:0] o_head
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;

   assign w_full = (r_count == CNT_W'(DEPTH));
   assign w_pop  = i_pop && (r_count != '0);
   // A push into a full buffer is only safe when the head leaves on the same edge
   assign w_push = i_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = (r_count != '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/elastic_memory_responder.sv
// Memory responder for an elastic ALU: stores complete in one cycle, loads
// return after LOAD_LATENCY cycles through a response buffer.
module elastic_memory_responder
   import elastic_memory_responder_pkg::*;
#(
   parameter int DATA_WIDTH    = elastic_memory_responder_pkg::DATA_WIDTH,
   parameter int ADDRESS_WIDTH = elastic_memory_responder_pkg::ADDRESS_WIDTH,
   parameter int LOAD_LATENCY  = elastic_memory_responder_pkg::LOAD_CYCLE,
   parameter int RESP_DEPTH    = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     request_valid,
   output logic                     request_stop,
   input  logic                     request_write,
   input  logic [ADDRESS_WIDTH-1:0] request_address,
   input  logic [DATA_WIDTH-1:0]    request_data,
   output logic                     response_valid,
   input  logic                     response_stop,
   output logic [DATA_WIDTH-1:0]    response_data,
   output logic                     busy
);

   localparam int CTR_W = $clog2(LOAD_LATENCY + 1);
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);

   resp_state_t            r_state;
   resp_state_t            w_state_nxt;
   logic [CTR_W-1:0]       r_counter;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0]  r_mem [2**ADDRESS_WIDTH];

   logic                   w_req_fire;
   logic                   w_load_fire;
   logic                   w_store_fire;
   logic                   w_load_done;
   logic                   w_resp_valid;
   logic [CNT_W-1:0]       w_count;

   assign request_stop = (r_state == WAIT) || (w_count == CNT_W'(RESP_DEPTH));
   assign w_req_fire   = request_valid && !request_stop;
   assign w_load_fire  = w_req_fire && !request_write;
   assign w_store_fire = w_req_fire && request_write;
   assign w_load_done  = (r_state == WAIT) && (r_counter == CTR_W'(1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_load_fire) w_state_nxt = WAIT;
         WAIT:    if (w_load_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_counter <= '0;
         r_addr    <= '0;
      end else if (w_load_fire) begin
         r_counter <= CTR_W'(LOAD_LATENCY);
         r_addr    <= request_address;
      end else if (r_state == WAIT) begin
         r_counter <= r_counter - 1'b1;
      end
   end

   // Data array is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (w_store_fire) r_mem[request_address] <= request_data;
   end

   elastic_response_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RESP_DEPTH)
   ) u_resp_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_load_done),
      .i_push_data (r_mem[r_addr]),
      .i_pop       (!response_stop),
      .o_valid     (w_resp_valid),
      .o_count     (w_count),
      .o_head      (response_data)
   );

   assign response_valid = w_resp_valid;
   assign busy           = (r_state == WAIT) || w_resp_valid;

endmodule

// File: tb/tb_elastic_memory_responder.sv
// Directed bench for elastic_memory_responder (LOAD_LATENCY=2, RESP_DEPTH=2).
module tb_elastic_memory_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        request_valid;
   logic        request_stop;
   logic        request_write;
   logic [9:0]  request_address;
   logic [31:0] request_data;
   logic        response_valid;
   logic        response_stop;
   logic [31:0] response_data;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   elastic_memory_responder #(
      .DATA_WIDTH    (32),
      .ADDRESS_WIDTH (10),
      .LOAD_LATENCY  (2),
      .RESP_DEPTH    (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .request_valid   (request_valid),
      .request_stop    (request_stop),
      .request_write   (request_write),
      .request_address (request_address),
      .request_data    (request_data),
      .response_valid  (response_valid),
      .response_stop   (response_stop),
      .response_data   (response_data),
      .busy            (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [9:0] a, input logic [31:0] d);
      request_valid = 1'b1; request_write = 1'b1;
      request_address = a;  request_data = d;
      tick();
      request_valid = 1'b0; request_write = 1'b0;
   endtask

   // Single load with response_stop low: accept, wait LOAD_LATENCY, check, pop
   task automatic load_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
      request_valid = 1'b1; request_write = 1'b0; request_address = a;
      tick();
      request_valid = 1'b0;
      tick();
      chk({tag, "_early"}, {31'd0, response_valid}, 32'd0);
      tick();
      chk({tag, "_valid"}, {31'd0, response_valid}, 32'd1);
      chk({tag, "_data"}, response_data, exp);
      tick();
      chk({tag, "_popped"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; request_valid = 1'b0; request_write = 1'b0;
      request_address = '0; request_data = '0; response_stop = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_stop",  {31'd0, request_stop},   32'd0);
      chk("rst_rv",    {31'd0, response_valid}, 32'd0);
      chk("rst_rdata", response_data,           32'd0);
      chk("rst_busy",  {31'd0, busy},           32'd0);

      // store then load on consecutive accepting edges
      store(10'd5, 32'h1234);
      chk("st_busy", {31'd0, busy}, 32'd0);
      chk("st_stop", {31'd0, request_stop}, 32'd0);
      request_valid = 1'b1; request_address = 10'd5;
      tick();
      request_valid = 1'b0;
      chk("ld_stop_e0", {31'd0, request_stop}, 32'd1);
      chk("ld_busy_e0", {31'd0, busy}, 32'd1);
      chk("ld_rv_e0",   {31'd0, response_valid}, 32'd0);
      tick();
      chk("ld_stop_e1", {31'd0, request_stop}, 32'd1);
      chk("ld_rv_e1",   {31'd0, response_valid}, 32'd0);
      tick();
      chk("ld_rv_e2",   {31'd0, response_valid}, 32'd1);
      chk("ld_data_e2", response_data, 32'h1234);
      chk("ld_stop_e2", {31'd0, request_stop}, 32'd0);
      tick();
      chk("ld_busy_pop", {31'd0, busy}, 32'd0);

      // address change during WAIT must not affect returned data
      request_valid = 1'b1; request_address = 10'd5;
      tick();
      request_address = 10'd1;
      tick();
      chk("hold_stop", {31'd0, request_stop}, 32'd1);
      request_valid = 1'b0; request_address = 10'd3;
      tick();
      chk("hold_data", response_data, 32'h1234);
      tick();

      // backpressure: buffer fills, third load held off
      store(10'd1, 32'd10);
      store(10'd2, 32'd20);
      store(10'd3, 32'd30);
      response_stop = 1'b1;
      request_valid = 1'b1; request_address = 10'd1;
      tick();
      request_address = 10'd2;
      tick();
      tick();
      chk("bp_rv1",   {31'd0, response_valid}, 32'd1);
      chk("bp_head1", response_data, 32'd10);
      chk("bp_stop1", {31'd0, request_stop}, 32'd0);
      tick();
      request_address = 10'd3;
      tick(); tick();
      chk("bp_full_stop", {31'd0, request_stop}, 32'd1);
      chk("bp_full_head", response_data, 32'd10);
      tick(); tick();
      chk("bp_still_stop", {31'd0, request_stop}, 32'd1);
      response_stop = 1'b0;
      tick();
      chk("bp_head2", response_data, 32'd20);
      chk("bp_rv2",   {31'd0, response_valid}, 32'd1);
      tick();
      request_valid = 1'b0;
      chk("bp_ld3_rv",   {31'd0, response_valid}, 32'd0);
      chk("bp_ld3_stop", {31'd0, request_stop}, 32'd1);
      chk("bp_ld3_busy", {31'd0, busy}, 32'd1);
      tick(); tick();
      chk("bp_head3", response_data, 32'd30);
      chk("bp_rv3",   {31'd0, response_valid}, 32'd1);
      tick();
      chk("bp_idle", {31'd0, busy}, 32'd0);

      // push and pop on the same edge with one entry buffered
      response_stop = 1'b1;
      request_valid = 1'b1; request_address = 10'd1;
      tick();
      request_valid = 1'b0;
      tick(); tick();
      chk("pp_head_a", response_data, 32'd10);
      request_valid = 1'b1; request_address = 10'd2;
      tick();
      request_valid = 1'b0;
      tick();
      chk("pp_head_hold", response_data, 32'd10);
      response_stop = 1'b0;
      tick();
      chk("pp_rv",   {31'd0, response_valid}, 32'd1);
      chk("pp_head", response_data, 32'd20);
      chk("pp_stop", {31'd0, request_stop}, 32'd0);
      tick();
      chk("pp_drain", {31'd0, response_valid}, 32'd0);

      // reset one cycle into WAIT drops the pending load
      request_valid = 1'b1; request_address = 10'd5;
      tick();
      request_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_stop", {31'd0, request_stop},   32'd0);
      chk("mid_rst_rv",   {31'd0, response_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy},           32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mid_rst_no_resp", {31'd0, response_valid}, 32'd0);
      end
      load_chk("mem_kept", 10'd5, 32'h1234);

      // address range extremes
      store(10'd1023, 32'hDEADBEEF);
      store(10'd0,    32'hCAFEF00D);
      load_chk("addr_top",  10'd1023, 32'hDEADBEEF);
      load_chk("addr_zero", 10'd0,    32'hCAFEF00D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
